rv_decode_buffer: RTL and testbench
===================================

Name: rv_decode_buffer

Overview:
- Parametrised instruction decode buffer for the RISC-V DUT path. It accepts 32-bit instruction words with their PC over a valid/ready handshake.
- Decodes each word into format, register fields, funct fields and a fully assembled, sign-extended immediate, covering the R/I/S/B/U/J/custom-0 opcode set.
- Buffers decoded entries in a DEPTH-entry FIFO and presents the head over a second valid/ready handshake.
- Serves as the RTL counterpart and golden-decode source for the instruction-type definitions used by the UVM environment.

Parameters:
- XLEN, 32: PC and immediate width; legal values 32 or 64.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all buffered entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  buffer can accept this cycle.
- in_inst  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_inst.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_pc  out  XLEN  PC of head.
- out_opcode  out  7  inst[6:0].
- out_format  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=CUSTOM0, 7=UNKNOWN.
- out_rd, out_rs1, out_rs2  out  5 each  inst[11:7], inst[19:15], inst[24:20]; forced to 0 when the format does not use the field.
- out_funct3  out  3  inst[14:12]; 0 for U and J.
- out_funct7  out  7  inst[31:25]; 0 unless R.
- out_imm  out  XLEN  assembled immediate.
- out_illegal  out  1  head is illegal.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset: count=0, out_valid=0, in_ready=0 in the reset cycle and 1 from the next cycle. All out_* data is 0. Reset mid-operation discards every entry.
- Handshake:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = !rst && !flush && (count < DEPTH). A full buffer does not accept a push even if a pop occurs in the same cycle (no pass-through).
- Decode happens combinationally at the write side; the decoded entry is stored. Latency: an entry accepted in cycle N is visible with out_valid=1 in cycle N+1 when the buffer was empty.
- Data outputs hold the head entry and are stable while out_valid && !out_ready.
- Ordering is strictly FIFO. Pointers wrap modulo DEPTH.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged.
- Flush: count=0 and out_valid=0 next cycle. An in_valid offered during flush is not accepted (in_ready=0). Flush has priority over push and pop. Reset has priority over flush.
- Immediates, where s() means sign-extend to XLEN:
  - I: s(inst[31:20]).
  - S: s({inst[31:25], inst[11:7]}).
  - B: s({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: s({inst[31:12], 12'b0}).
  - J: s({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - R, CUSTOM0, UNKNOWN: 0.
- Format is selected by opcode: 0110011=R, 0010011=I, 0100011=S, 1100011=B, 0010111=U, 1101111=J, 0001011=CUSTOM0, otherwise UNKNOWN.
- Illegal when any of:
  - format UNKNOWN;
  - I with funct3=001 and the upper field is nonzero;
  - I with funct3=101 and the upper field is not 0 and not the SRAI code;
  - S with funct3 > 010;
  - CUSTOM0 with funct3 != 000;
  - R with funct7 not in {0000000, 0100000}.
- The upper field for the I-type shift checks is inst[31:25] when XLEN=32 and inst[31:26] when XLEN=64. The SRAI code is 0100000 (XLEN=32) or 010000 (XLEN=64).
- Illegal entries are still buffered and delivered, with out_illegal=1.

Optional Feature:
- Macro: RV_DECODE_STATS_EN.
- Defined:
  - Adds outputs issued_cnt (32) and illegal_cnt (16).
  - Both increment on each pop; illegal_cnt only on pops where out_illegal=1.
  - Both saturate at all-ones, clear on rst, and are unaffected by flush.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single ADDI: push 0xFFF10093 at PC 0x100, out_ready=1. Next cycle: out_valid=1, format=1, rd=1, rs1=2, funct3=0, imm=0xFFFFFFFF, illegal=0, pc=0x100.
- B and J immediates:
  - Push 0xFE000EE3: format=3, imm=0xFFFFFFFC, rs1=rs2=0.
  - Push 0x0080006F: format=5, imm=0x00000008, rd=0.
  - Delivered in order.
- Full/backpressure (DEPTH=4, out_ready=0): push 5 words back-to-back. First 4 accepted, count=4, in_ready=0 on the 5th. Raise out_ready with in_valid held: pop occurs, in_ready returns 1 the following cycle, the 5th word is accepted, order is preserved.
- Illegal detection:
  - 0x0000007F gives format=7, illegal=1, imm=0.
  - 0x40109093 (SLLI, bit30 set) gives format=1, illegal=1.
  - 0x0000100B (CUSTOM0, funct3=1) gives illegal=1.
- Flush/reset: with count=3, assert flush together with in_valid for one cycle. Next cycle count=0 and out_valid=0, and the offered word is absent. Repeat with rst instead of flush: all outputs 0.
- Stats (RV_DECODE_STATS_EN, XLEN=64): pop 3 legal and 2 illegal words. Result: issued_cnt=5, illegal_cnt=2, and a U word 0x80000097 gives imm=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/rv_decode_buffer_if.sv
// rtl/rv_decode_buffer_if.sv - Write-side and read-side handshake bundle for rv_decode_buffer.
interface rv_decode_buffer_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_format;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_format, out_rd, out_rs1,
           out_rs2, out_funct3, out_funct7, out_imm, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_format, out_rd, out_rs1,
           out_rs2, out_funct3, out_funct7, out_imm, out_illegal
  );
endinterface

// File: rtl/rv_decode_buffer.sv
// rtl/rv_decode_buffer.sv - RISC-V decode-at-write FIFO; RV_DECODE_STATS_EN adds pop counters.
module rv_decode_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  rv_decode_buffer_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef RV_DECODE_STATS_EN
  ,
  output logic [31:0]                  issued_cnt,
  output logic [15:0]                  illegal_cnt
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_CUSTOM0 = 3'd6,
    FMT_UNKNOWN = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      fmt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  entry_t          dec;
  entry_t          head;
  entry_t          head_vis;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready;
  logic            out_valid;
  logic            push, pop;
  fmt_e            fmt;
  logic [31:0]     inst;
  logic            upper_nz, upper_srai;

  // Shift-immediate upper field shrinks by one bit on RV64 because shamt grows to 6 bits.
  always_comb begin
    inst = bus.in_inst;
    if (XLEN == 64) begin
      upper_nz   = |inst[31:26];
      upper_srai = (inst[31:26] == 6'b010000);
    end else begin
      upper_nz   = |inst[31:25];
      upper_srai = (inst[31:25] == 7'b0100000);
    end
  end

  always_comb begin
    unique case (inst[6:0])
      7'b0110011: fmt = FMT_R;
      7'b0010011: fmt = FMT_I;
      7'b0100011: fmt = FMT_S;
      7'b1100011: fmt = FMT_B;
      7'b0010111: fmt = FMT_U;
      7'b1101111: fmt = FMT_J;
      7'b0001011: fmt = FMT_CUSTOM0;
      default:    fmt = FMT_UNKNOWN;
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.pc     = bus.in_pc;
    dec.opcode = inst[6:0];
    dec.fmt    = fmt;
    dec.funct3 = inst[14:12];
    unique case (fmt)
      FMT_R: begin
        dec.rd      = inst[11:7];
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.funct7  = inst[31:25];
        dec.illegal = !((inst[31:25] == 7'b0000000) || (inst[31:25] == 7'b0100000));
      end
      FMT_I: begin
        dec.rd  = inst[11:7];
        dec.rs1 = inst[19:15];
        dec.imm = XLEN'($signed(inst[31:20]));
        if (inst[14:12] == 3'b001)
          dec.illegal = upper_nz;
        else if (inst[14:12] == 3'b101)
          dec.illegal = upper_nz && !upper_srai;
      end
      FMT_S: begin
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.imm     = XLEN'($signed({inst[31:25], inst[11:7]}));
        dec.illegal = (inst[14:12] > 3'b010);
      end
      FMT_B: begin
        dec.rs1 = inst[19:15];
        dec.rs2 = inst[24:20];
        dec.imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      end
      FMT_U: begin
        dec.rd     = inst[11:7];
        dec.funct3 = 3'd0;
        dec.imm    = XLEN'($signed({inst[31:12], 12'b0}));
      end
      FMT_J: begin
        dec.rd     = inst[11:7];
        dec.funct3 = 3'd0;
        dec.imm    = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      end
      FMT_CUSTOM0: begin
        dec.rd      = inst[11:7];
        dec.rs1     = inst[19:15];
        dec.rs2     = inst[24:20];
        dec.illegal = (inst[14:12] != 3'b000);
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // No pass-through: a full buffer refuses a push even while popping.
  assign in_ready  = !rst && !flush && (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready && !flush;
  assign head      = mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = dec;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop)
        rptr_d = rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Stale storage never leaks: data outputs read zero whenever the buffer is empty.
  assign head_vis = out_valid ? head : '0;

  always_comb begin
    bus.in_ready    = in_ready;
    bus.out_valid   = out_valid;
    bus.out_pc      = head_vis.pc;
    bus.out_opcode  = head_vis.opcode;
    bus.out_format  = head_vis.fmt;
    bus.out_rd      = head_vis.rd;
    bus.out_rs1     = head_vis.rs1;
    bus.out_rs2     = head_vis.rs2;
    bus.out_funct3  = head_vis.funct3;
    bus.out_funct7  = head_vis.funct7;
    bus.out_imm     = head_vis.imm;
    bus.out_illegal = head_vis.illegal;
    count           = count_q;
  end

`ifdef RV_DECODE_STATS_EN
  logic [31:0] issued_q, issued_d;
  logic [15:0] illegal_q, illegal_d;

  always_comb begin
    issued_d  = issued_q;
    illegal_d = illegal_q;
    if (pop && (issued_q != '1))
      issued_d = issued_q + 1'b1;
    if (pop && head.illegal && (illegal_q != '1))
      illegal_d = illegal_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q  <= '0;
      illegal_q <= '0;
    end else begin
      issued_q  <= issued_d;
      illegal_q <= illegal_d;
    end
  end

  assign issued_cnt  = issued_q;
  assign illegal_cnt = illegal_q;
`endif
endmodule

// File: tb/tb_rv_decode_buffer.sv
// tb/tb_rv_decode_buffer.sv - Directed self-checking bench for rv_decode_buffer.
module tb_rv_decode_buffer;
`ifdef RV_DECODE_STATS_EN
  localparam int XLEN = 64;
`else
  localparam int XLEN = 32;
`endif
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [$clog2(DEPTH+1)-1:0] count;
`ifdef RV_DECODE_STATS_EN
  logic [31:0] issued_cnt;
  logic [15:0] illegal_cnt;
`endif
  int n_cmp = 0;
  int n_err = 0;

  rv_decode_buffer_if #(.XLEN(XLEN)) bus ();

  rv_decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .count       (count)
`ifdef RV_DECODE_STATS_EN
    ,
    .issued_cnt  (issued_cnt),
    .illegal_cnt (illegal_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    logic [XLEN-1:0] t;
    t = XLEN'($signed(v));
    return 64'(t);
  endfunction

  function automatic logic [31:0] addi0(input int i);
    return 32'h00000013 | (32'(i) << 20);
  endfunction

  task automatic push(input logic [31:0] inst, input logic [XLEN-1:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop1();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_imm", 64'(bus.out_imm), 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single ADDI
    bus.out_ready = 1'b1;
    push(32'hFFF10093, XLEN'('h100));
    chk("addi_valid", 64'(bus.out_valid), 64'd1);
    chk("addi_format", 64'(bus.out_format), 64'd1);
    chk("addi_rd", 64'(bus.out_rd), 64'd1);
    chk("addi_rs1", 64'(bus.out_rs1), 64'd2);
    chk("addi_funct3", 64'(bus.out_funct3), 64'd0);
    chk("addi_imm", 64'(bus.out_imm), sx(32'hFFFFFFFF));
    chk("addi_illegal", 64'(bus.out_illegal), 64'd0);
    chk("addi_pc", 64'(bus.out_pc), 64'h100);
    step();
    bus.out_ready = 1'b0;
    chk("addi_drained", 64'(count), 64'd0);

    // B and J immediates, in order
    push(32'hFE000EE3, XLEN'('h200));
    push(32'h0080006F, XLEN'('h204));
    chk("bj_count", 64'(count), 64'd2);
    chk("b_format", 64'(bus.out_format), 64'd3);
    chk("b_imm", 64'(bus.out_imm), sx(32'hFFFFFFFC));
    chk("b_rs1", 64'(bus.out_rs1), 64'd0);
    chk("b_rs2", 64'(bus.out_rs2), 64'd0);
    chk("b_pc", 64'(bus.out_pc), 64'h200);
    pop1();
    chk("j_format", 64'(bus.out_format), 64'd5);
    chk("j_imm", 64'(bus.out_imm), 64'h8);
    chk("j_rd", 64'(bus.out_rd), 64'd0);
    chk("j_pc", 64'(bus.out_pc), 64'h204);
    pop1();
    chk("bj_drained", 64'(count), 64'd0);

    // Full buffer and backpressure
    for (int i = 0; i < 4; i++) push(addi0(i), XLEN'(32'h300 + 4 * i));
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    bus.in_inst  = addi0(4);
    bus.in_pc    = XLEN'('h310);
    step();
    chk("full_reject_count", 64'(count), 64'd4);
    chk("full_head_imm0", 64'(bus.out_imm), 64'd0);
    bus.out_ready = 1'b1;
    step();
    chk("bp_pop_count", 64'(count), 64'd3);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("bp_refill_count", 64'(count), 64'd4);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("bp_order_%0d", i), 64'(bus.out_imm), 64'(i));
      step();
    end
    bus.out_ready = 1'b0;
    chk("bp_drained", 64'(count), 64'd0);

    // Simultaneous push and pop keeps occupancy
    push(addi0(7), XLEN'('h400));
    bus.in_valid  = 1'b1;
    bus.in_inst   = addi0(8);
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("pp_count", 64'(count), 64'd1);
    chk("pp_head", 64'(bus.out_imm), 64'd8);
    pop1();

    // Illegal and other formats
    push(32'h0000007F, XLEN'('h500));
    chk("unk_format", 64'(bus.out_format), 64'd7);
    chk("unk_illegal", 64'(bus.out_illegal), 64'd1);
    chk("unk_imm", 64'(bus.out_imm), 64'd0);
    pop1();
    push(32'h40109093, XLEN'('h504));
    chk("slli_format", 64'(bus.out_format), 64'd1);
    chk("slli_illegal", 64'(bus.out_illegal), 64'd1);
    pop1();
    push(32'h0000100B, XLEN'('h508));
    chk("c0_format", 64'(bus.out_format), 64'd6);
    chk("c0_illegal", 64'(bus.out_illegal), 64'd1);
    pop1();
    push(32'h002081B3, XLEN'('h50C));
    chk("r_rd", 64'(bus.out_rd), 64'd3);
    chk("r_rs1", 64'(bus.out_rs1), 64'd1);
    chk("r_rs2", 64'(bus.out_rs2), 64'd2);
    chk("r_illegal", 64'(bus.out_illegal), 64'd0);
    pop1();
    push(32'h0020A423, XLEN'('h510));
    chk("s_format", 64'(bus.out_format), 64'd2);
    chk("s_imm", 64'(bus.out_imm), 64'd8);
    chk("s_rd", 64'(bus.out_rd), 64'd0);
    chk("s_funct3", 64'(bus.out_funct3), 64'd2);
    pop1();

    // Flush with a concurrent offer
    for (int i = 0; i < 3; i++) push(addi0(10 + i), XLEN'(32'h600 + 4 * i));
    chk("fl_pre_count", 64'(count), 64'd3);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_inst  = addi0(20);
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_out_valid", 64'(bus.out_valid), 64'd0);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) push(addi0(30 + i), XLEN'(32'h700 + 4 * i));
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_inst  = addi0(40);
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("mr_count", 64'(count), 64'd0);
    chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_pc", 64'(bus.out_pc), 64'd0);
    chk("mr_opcode", 64'(bus.out_opcode), 64'd0);
    chk("mr_imm", 64'(bus.out_imm), 64'd0);

    // Stream five words straight through: three legal, two illegal
    bus.out_ready = 1'b1;
    push(32'hFFF10093, XLEN'('h800));
    push(32'h002081B3, XLEN'('h804));
    push(32'h0000007F, XLEN'('h808));
    push(32'h0020A423, XLEN'('h80C));
    push(32'h40109093, XLEN'('h810));
    step();
    bus.out_ready = 1'b0;
    chk("st_drained", 64'(count), 64'd0);
`ifdef RV_DECODE_STATS_EN
    chk("st_issued", 64'(issued_cnt), 64'd5);
    chk("st_illegal", 64'(illegal_cnt), 64'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("st_issued_after_flush", 64'(issued_cnt), 64'd5);
    chk("st_illegal_after_flush", 64'(illegal_cnt), 64'd2);
`endif

    // U-type sign extension
    push(32'h80000097, XLEN'('h900));
    chk("u_format", 64'(bus.out_format), 64'd4);
    chk("u_rd", 64'(bus.out_rd), 64'd1);
    chk("u_funct3", 64'(bus.out_funct3), 64'd0);
`ifdef RV_DECODE_STATS_EN
    chk("u_imm", 64'(bus.out_imm), 64'hFFFFFFFF80000000);
`else
    chk("u_imm", 64'(bus.out_imm), 64'h80000000);
`endif
    pop1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
